// File: rtl/vga_output_stage.sv
`default_nettype none
// ============================================================================
//  Module      : vga_output_stage
//  Description : Final pixel stage ahead of the VGA pins. Delay-aligns
//                sync/enable with the drawer pipeline, applies a frame-
//                synchronous brightness fade and drives status LEDs.
//  Revision    : 1.0  initial release
// ============================================================================
module vga_output_stage #(
   parameter int COLOR_BITS       = 4,
   parameter int BRIGHT_BITS      = 4,
   parameter int PIPE_DEPTH       = 2,
   parameter int FADE_FRAMES      = 2,
   parameter int RESET_BLACK      = 0,
   parameter int HEARTBEAT_CYCLES = 2_500_000,
   parameter int LED_COUNT        = 10
) (
   input  logic                  vga_clock,
   input  logic                  reset,
   input  logic [COLOR_BITS-1:0] red_in,
   input  logic [COLOR_BITS-1:0] green_in,
   input  logic [COLOR_BITS-1:0] blue_in,
   input  logic                  display_enable,
   input  logic                  hsync_in,
   input  logic                  vsync_in,
   input  logic [1:0]            fade_cmd,
   output logic [COLOR_BITS-1:0] vga_red,
   output logic [COLOR_BITS-1:0] vga_green,
   output logic [COLOR_BITS-1:0] vga_blue,
   output logic                  vga_hsync,
   output logic                  vga_vsync,
   output logic                  fade_done,
   output logic [LED_COUNT-1:0]  leds
);

   localparam int C_PW = COLOR_BITS + BRIGHT_BITS + 1;
   localparam int C_LW = BRIGHT_BITS + 1;
   localparam int C_FW = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
   localparam int C_HW = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;

   localparam logic [C_LW-1:0] C_LEVEL_MAX = {1'b1, {BRIGHT_BITS{1'b0}}};
   localparam logic [C_LW-1:0] C_LEVEL_ONE = C_LW'(1);
   localparam logic [C_FW-1:0] C_FF_LAST   = C_FW'(FADE_FRAMES - 1);
   localparam logic [C_FW-1:0] C_FF_ONE    = C_FW'(1);
   localparam logic [C_HW-1:0] C_HB_LAST   = C_HW'(HEARTBEAT_CYCLES - 1);
   localparam logic [C_HW-1:0] C_HB_ONE    = C_HW'(1);

   typedef enum logic [1:0] {
      S_FULL     = 2'd0,
      S_BLACK    = 2'd1,
      S_FADE_IN  = 2'd2,
      S_FADE_OUT = 2'd3
   } state_t;

   localparam state_t C_RST_STATE = (RESET_BLACK != 0) ? S_BLACK : S_FULL;
   localparam logic [C_LW-1:0] C_RST_LEVEL = (RESET_BLACK != 0) ? '0 : C_LEVEL_MAX;

   // {enable, hsync, vsync} before and after the drawer-latency delay line
   logic [2:0] w_sync_in;
   logic [2:0] w_sync_d;
   assign w_sync_in = {display_enable, hsync_in, vsync_in};

   generate
      if (PIPE_DEPTH > 0) begin : g_pipe
         logic [2:0] r_sr [PIPE_DEPTH];
         // Delay enable/syncs by the drawer latency; idle value is blank, syncs high
         always_ff @(posedge vga_clock or negedge reset) begin
            if (!reset) begin
               for (int i = 0; i < PIPE_DEPTH; i++) r_sr[i] <= 3'b011;
            end else begin
               r_sr[0] <= w_sync_in;
               for (int i = 1; i < PIPE_DEPTH; i++) r_sr[i] <= r_sr[i-1];
            end
         end
         assign w_sync_d = r_sr[PIPE_DEPTH-1];
      end else begin : g_nopipe
         assign w_sync_d = w_sync_in;
      end
   endgenerate

   // Brightness state
   state_t          r_state, w_state_nx;
   logic [C_LW-1:0] r_level, w_level_nx;
   logic [C_FW-1:0] r_fcnt,  w_fcnt_nx;
   logic            r_done,  w_done_nx;
   logic            w_cmd_taken;

   // Stage registers
   logic [COLOR_BITS-1:0] r_red1, r_green1, r_blue1;
   logic [COLOR_BITS-1:0] r_red,  r_green,  r_blue;
   logic                  r_en1, r_hs1, r_vs1, r_hs, r_vs;

   // Frame boundary: falling edge of the delayed vsync
   logic w_frame_tick;
   assign w_frame_tick = r_vs1 & ~w_sync_d[0];

   // Scaling products; only the middle COLOR_BITS slice is the result
   logic [C_PW-1:0] w_prod_r, w_prod_g, w_prod_b;
   assign w_prod_r = C_PW'(red_in)   * C_PW'(r_level);
   assign w_prod_g = C_PW'(green_in) * C_PW'(r_level);
   assign w_prod_b = C_PW'(blue_in)  * C_PW'(r_level);

   logic w_unused;
   assign w_unused = ^{w_prod_r[C_PW-1], w_prod_r[BRIGHT_BITS-1:0],
                       w_prod_g[C_PW-1], w_prod_g[BRIGHT_BITS-1:0],
                       w_prod_b[C_PW-1], w_prod_b[BRIGHT_BITS-1:0]};

   // Stage 1: scale colour and carry aligned sync/enable alongside it
   always_ff @(posedge vga_clock or negedge reset) begin
      if (!reset) begin
         r_red1   <= '0;
         r_green1 <= '0;
         r_blue1  <= '0;
         r_en1    <= 1'b0;
         r_hs1    <= 1'b1;
         r_vs1    <= 1'b1;
      end else begin
         r_red1   <= w_prod_r[BRIGHT_BITS +: COLOR_BITS];
         r_green1 <= w_prod_g[BRIGHT_BITS +: COLOR_BITS];
         r_blue1  <= w_prod_b[BRIGHT_BITS +: COLOR_BITS];
         r_en1    <= w_sync_d[2];
         r_hs1    <= w_sync_d[1];
         r_vs1    <= w_sync_d[0];
      end
   end

   // Stage 2: pin registers, colour blanked outside active video
   always_ff @(posedge vga_clock or negedge reset) begin
      if (!reset) begin
         r_red   <= '0;
         r_green <= '0;
         r_blue  <= '0;
         r_hs    <= 1'b1;
         r_vs    <= 1'b1;
      end else begin
         r_red   <= r_en1 ? r_red1   : '0;
         r_green <= r_en1 ? r_green1 : '0;
         r_blue  <= r_en1 ? r_blue1  : '0;
         r_hs    <= r_hs1;
         r_vs    <= r_vs1;
      end
   end

   // Fade state register
   always_ff @(posedge vga_clock or negedge reset) begin
      if (!reset) begin
         r_state <= C_RST_STATE;
         r_level <= C_RST_LEVEL;
         r_fcnt  <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_level <= w_level_nx;
         r_fcnt  <= w_fcnt_nx;
         r_done  <= w_done_nx;
      end
   end

   // Fade next-state: an effective command pre-empts any frame step this cycle
   always_comb begin
      w_state_nx  = r_state;
      w_level_nx  = r_level;
      w_fcnt_nx   = r_fcnt;
      w_done_nx   = 1'b0;
      w_cmd_taken = 1'b0;
      case (fade_cmd)
         2'b11: begin
            w_state_nx  = S_FULL;
            w_level_nx  = C_LEVEL_MAX;
            w_fcnt_nx   = '0;
            w_cmd_taken = 1'b1;
         end
         2'b01: begin
            if ((r_level != C_LEVEL_MAX) && (r_state != S_FADE_IN)) begin
               w_state_nx  = S_FADE_IN;
               w_fcnt_nx   = '0;
               w_cmd_taken = 1'b1;
            end
         end
         2'b10: begin
            if ((r_level != '0) && (r_state != S_FADE_OUT)) begin
               w_state_nx  = S_FADE_OUT;
               w_fcnt_nx   = '0;
               w_cmd_taken = 1'b1;
            end
         end
         default: ;
      endcase
      if (!w_cmd_taken && w_frame_tick) begin
         if (r_fcnt == C_FF_LAST) begin
            w_fcnt_nx = '0;
            if (r_state == S_FADE_IN) begin
               w_level_nx = r_level + C_LEVEL_ONE;
               if (r_level == C_LEVEL_MAX - C_LEVEL_ONE) begin
                  w_state_nx = S_FULL;
                  w_done_nx  = 1'b1;
               end
            end else if (r_state == S_FADE_OUT) begin
               w_level_nx = r_level - C_LEVEL_ONE;
               if (r_level == C_LEVEL_ONE) begin
                  w_state_nx = S_BLACK;
                  w_done_nx  = 1'b1;
               end
            end
         end else begin
            w_fcnt_nx = r_fcnt + C_FF_ONE;
         end
      end
   end

   // Status LEDs: heartbeat, alive flag and frame-tick toggle
   logic            r_hb_led, r_alive, r_tick_led;
   logic [C_HW-1:0] r_hb_cnt;

   // Heartbeat divider, alive flag and per-frame toggle
   always_ff @(posedge vga_clock or negedge reset) begin
      if (!reset) begin
         r_hb_cnt   <= '0;
         r_hb_led   <= 1'b0;
         r_alive    <= 1'b0;
         r_tick_led <= 1'b0;
      end else begin
         r_alive <= 1'b1;
         if (r_hb_cnt == C_HB_LAST) begin
            r_hb_cnt <= '0;
            r_hb_led <= ~r_hb_led;
         end else begin
            r_hb_cnt <= r_hb_cnt + C_HB_ONE;
         end
         if (w_frame_tick) r_tick_led <= ~r_tick_led;
      end
   end

   assign leds[0] = r_hb_led;
   assign leds[1] = r_alive;
   assign leds[2] = (r_state == S_FADE_IN) || (r_state == S_FADE_OUT);
   assign leds[3] = r_tick_led;

   generate
      if (LED_COUNT > 4) begin : g_led_pad
         assign leds[LED_COUNT-1:4] = '0;
      end
   endgenerate

   assign vga_red   = r_red;
   assign vga_green = r_green;
   assign vga_blue  = r_blue;
   assign vga_hsync = r_hs;
   assign vga_vsync = r_vs;
   assign fade_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_vga_output_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_output_stage
//  Description : Directed self-checking bench for vga_output_stage
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vga_output_stage;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] red_in, green_in, blue_in;
   logic       display_enable, hsync_in, vsync_in;
   logic [1:0] fade_cmd;
   logic [3:0] vga_red, vga_green, vga_blue;
   logic       vga_hsync, vga_vsync, fade_done;
   logic [9:0] leds;

   int n_checks = 0;
   int n_fail   = 0;
   int ticks    = 0;
   int done_cnt = 0;
   int base     = 0;
   int lvl      = 0;
   int k        = 0;
   logic hb0;

   vga_output_stage #(
      .COLOR_BITS(4), .BRIGHT_BITS(4), .PIPE_DEPTH(2), .FADE_FRAMES(2),
      .RESET_BLACK(0), .HEARTBEAT_CYCLES(4), .LED_COUNT(10)
   ) dut (
      .vga_clock(clk), .reset(rst_n),
      .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
      .display_enable(display_enable), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .fade_cmd(fade_cmd),
      .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
      .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
      .fade_done(fade_done), .leds(leds)
   );

   always #5 clk = ~clk;

   // Count fade_done high cycles, sampled mid-cycle
   always @(negedge clk) if (fade_done === 1'b1) done_cnt++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cmd_pulse(input logic [1:0] c);
      fade_cmd = c;
      step();
      fade_cmd = 2'b00;
   endtask

   // One frame boundary; cmd lands in the same cycle the tick is seen
   task automatic vfall(input logic [1:0] c);
      vsync_in = 1'b0;
      step();
      step();
      fade_cmd = c;
      step();
      fade_cmd = 2'b00;
      vsync_in = 1'b1;
      repeat (5) step();
      ticks++;
   endtask

   function automatic int exp_red(input int l);
      return (15 * l) >> 4;
   endfunction

   initial begin
      rst_n = 1'b0; red_in = 4'hA; green_in = 4'h5; blue_in = 4'h3;
      display_enable = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1; fade_cmd = 2'b00;
      repeat (3) step();
      chk("rst_red", vga_red, 0);
      chk("rst_green", vga_green, 0);
      chk("rst_hsync", vga_hsync, 1);
      chk("rst_vsync", vga_vsync, 1);
      chk("rst_done", fade_done, 0);
      chk("rst_leds", leds, 0);

      // Latency: enable reaches the pins PIPE_DEPTH+2 cycles after release
      rst_n = 1'b1;
      step();
      chk("alive_led", leds[1], 1);
      step(); step();
      chk("lat_early", vga_red, 0);
      step();
      chk("lat_red", vga_red, 10);
      chk("lat_green", vga_green, 5);
      chk("lat_blue", vga_blue, 3);

      // Sync alignment: one-cycle hsync pulse appears 4 cycles later
      hsync_in = 1'b0;
      step();
      hsync_in = 1'b1;
      step(); step();
      chk("hs_early", vga_hsync, 1);
      step();
      chk("hs_low", vga_hsync, 0);
      step();
      chk("hs_width", vga_hsync, 1);

      // Blanking
      display_enable = 1'b0; red_in = 4'hF;
      repeat (6) step();
      chk("en_blank", vga_red, 0);
      display_enable = 1'b1;
      repeat (6) step();
      chk("en_back", vga_red, 15);

      // Heartbeat: find an edge, then expect period 4
      hb0 = leds[0]; k = 0;
      while (leds[0] == hb0 && k < 8) begin step(); k++; end
      chk("hb_seen", int'(leds[0] != hb0), 1);
      hb0 = leds[0];
      for (int i = 0; i < 3; i++) begin
         step();
         chk("hb_hold", leds[0], hb0);
      end
      step();
      chk("hb_toggle", leds[0], !hb0);

      // Fade-out 16 -> 0, one step per two ticks
      base = done_cnt;
      cmd_pulse(2'b10);
      for (int i = 1; i <= 32; i++) begin
         vfall(2'b00);
         lvl = 16 - i / 2;
         chk("fo_red", vga_red, exp_red(lvl));
         chk("fo_busy", leds[2], int'(lvl > 0));
         chk("fo_tick_led", leds[3], ticks % 2);
      end
      chk("fo_done", done_cnt - base, 1);

      // Snap from BLACK
      base = done_cnt;
      cmd_pulse(2'b11);
      step(); step();
      chk("snap_black", vga_red, 15);
      chk("snap_nodone", done_cnt - base, 0);

      // Reversal at level 8, with the command coincident with a step tick
      base = done_cnt;
      cmd_pulse(2'b10);
      for (int i = 1; i <= 16; i++) vfall(2'b00);
      chk("rv_at8", vga_red, exp_red(8));
      vfall(2'b00);
      chk("rv_pre", vga_red, exp_red(8));
      vfall(2'b01);
      chk("rv_coinc", vga_red, exp_red(8));
      chk("rv_busy", leds[2], 1);
      for (int j = 1; j <= 16; j++) begin
         vfall(2'b00);
         lvl = 8 + j / 2;
         chk("rv_red", vga_red, exp_red(lvl));
         chk("rv_busy", leds[2], int'(lvl < 16));
      end
      chk("rv_done", done_cnt - base, 1);
      chk("rv_tick_led", leds[3], ticks % 2);

      // Snap during fade-out at level 5
      base = done_cnt;
      cmd_pulse(2'b10);
      for (int i = 1; i <= 22; i++) vfall(2'b00);
      chk("sn_lvl5", vga_red, exp_red(5));
      cmd_pulse(2'b11);
      step(); step();
      chk("sn_full", vga_red, 15);
      chk("sn_idle", leds[2], 0);
      chk("sn_nodone", done_cnt - base, 0);

      // Reset mid-fade
      cmd_pulse(2'b10);
      for (int i = 1; i <= 4; i++) vfall(2'b00);
      chk("mr_lvl14", vga_red, exp_red(14));
      base = done_cnt;
      rst_n = 1'b0;
      #1;
      chk("mr_red", vga_red, 0);
      chk("mr_hsync", vga_hsync, 1);
      chk("mr_vsync", vga_vsync, 1);
      chk("mr_leds", leds, 0);
      chk("mr_done", fade_done, 0);
      step();
      rst_n = 1'b1;
      ticks = 0;
      repeat (6) step();
      chk("mr_post_red", vga_red, 15);
      chk("mr_post_idle", leds[2], 0);
      chk("mr_post_tick", leds[3], 0);
      chk("mr_nodone", done_cnt - base, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vga_output_stage.md
# vga_output_stage

Parametrised final pixel stage between the sprite/tile drawer and the VGA pins. Per-channel colour width is configurable. Sync and enable are delay-aligned with the drawer's pipeline latency. The block applies a frame-synchronous brightness fade (fade-in/fade-out for level transitions and game-over) and drives a generalised status-LED bank with a heartbeat.

## Interface
Parameters:
- COLOR_BITS, 4, bits per colour channel.
- BRIGHT_BITS, 4, brightness resolution; level range 0..2^BRIGHT_BITS inclusive.
- PIPE_DEPTH, 2, drawer latency in cycles applied to sync/enable (0 allowed).
- FADE_FRAMES, 2, frames per brightness step (>=1).
- RESET_BLACK, 0, 1 = level resets to 0 (state BLACK), 0 = level resets to full (state FULL).
- HEARTBEAT_CYCLES, 2_500_000, cycles between heartbeat toggles.
- LED_COUNT, 10, width of leds (>=4).

Ports:
- vga_clock, in, 1, pixel clock.
- reset, in, 1, asynchronous, active-low.
- red_in/green_in/blue_in, in, COLOR_BITS each, drawer colour, valid PIPE_DEPTH cycles after matching sync/enable.
- display_enable, in, 1, active-video flag from timing generator.
- hsync_in, vsync_in, in, 1 each, active-low syncs from timing generator.
- fade_cmd, in, 2, 00 hold, 01 fade-in, 10 fade-out, 11 snap to full.
- vga_red/vga_green/vga_blue, out, COLOR_BITS each, pin colour.
- vga_hsync, vga_vsync, out, 1 each, aligned syncs.
- fade_done, out, 1, one-cycle pulse when a fade reaches its target.
- leds, out, LED_COUNT, status LEDs.

## Operation
- Alignment: display_enable, hsync_in and vsync_in pass through a PIPE_DEPTH shift register. They are then registered through the same two stages as colour.
- Colour path, stage 1: scaled = (c * level) >> BRIGHT_BITS per channel. The product is COLOR_BITS+BRIGHT_BITS+1 bits wide, with no rounding. At level 2^BRIGHT_BITS the output equals the input exactly.
- Colour path, stage 2: output register. It loads scaled when the aligned enable is 1, otherwise 0.
- Frame tick: a falling edge (1->0) of aligned vsync, detected on the delayed signal. frame_cnt counts ticks 0..FADE_FRAMES-1 and wraps. A step is allowed on the tick where frame_cnt==FADE_FRAMES-1.
- FSM states:
  - FULL: level=2^B.
  - BLACK: level=0.
  - FADE_IN: level+1 per step.
  - FADE_OUT: level-1 per step.
- Commands are sampled every cycle:
  - 01 -> FADE_IN unless level is already max.
  - 10 -> FADE_OUT unless level is already 0.
  - 11 -> FULL immediately, level=max, frame_cnt=0, no fade_done.
  - 00 -> no change.
- Entering FADE_IN or FADE_OUT resets frame_cnt to 0.
- A command opposite to the current fade reverses direction from the current level. The same command as the current fade is ignored.
- FADE_IN reaching max -> FULL, fade_done=1 for one cycle. FADE_OUT reaching 0 -> BLACK, fade_done=1 for one cycle.
- Command and frame tick in the same cycle: the command wins; no step that cycle.
- LEDs:
  - leds[0]: toggles when hb_cnt==HEARTBEAT_CYCLES-1; hb_cnt then wraps to 0.
  - leds[1]: 1 from the first clock after reset.
  - leds[2]: 1 while in FADE_IN or FADE_OUT.
  - leds[3]: toggles on every frame tick.
  - leds[LED_COUNT-1:4]: 0.

## Timing
- Reset (async assert, sync-free deassert):
  - vga_red/green/blue = 0.
  - vga_hsync = vga_vsync = 1.
  - fade_done = 0; leds = 0.
  - Shift registers filled with enable=0, syncs=1.
  - level and state per RESET_BLACK; frame_cnt = hb_cnt = 0.
- Reset mid-fade abandons the fade. No fade_done is issued.
- Colour latency: 2 cycles from red_in to vga_red.
- Sync/enable latency: PIPE_DEPTH+2 cycles.
- Level update: the cycle after the frame tick is detected. It affects stage 1 from the next cycle. The frame-boundary edge is during vsync, so the change is invisible mid-frame.
- fade_done is asserted in the cycle the state register enters FULL or BLACK.

## Test plan
- Reset with RESET_BLACK=0, drive red_in=4'hA with enable high:
  - After PIPE_DEPTH+2 cycles, vga_red=4'hA.
  - Outputs are 0 and syncs are 1 during reset.
- Alignment, PIPE_DEPTH=2: pulse hsync_in low at cycle 10 -> vga_hsync low exactly at cycle 14, one cycle wide. With enable=0 the colour output is 0 regardless of inputs.
- Fade-out, FADE_FRAMES=2, B=4:
  - Issue 10, then drive 32 vsync falls -> level 16->0, stepping every 2nd tick.
  - red_in=15 gives 15,14,13,...,0.
  - fade_done pulses once; state BLACK; leds[2] high only during the fade.
- Reversal: at level 8 mid-fade-out, issue 01 -> level rises 9,10... to 16. One fade_done on reaching FULL. Command coincident with a tick -> no step that cycle.
- Snap: issue 11 during FADE_OUT at level 5 -> next cycle level=16, FULL, no fade_done. Assert reset mid-fade -> immediate reset values.
- Heartbeat with HEARTBEAT_CYCLES=4: leds[0] toggles every 4 cycles; leds[1]=1 from the first post-reset clock; leds[3] toggles on each vsync fall.
